// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   KEY_ENTER / KEY_DONE : key codes that map to the enter / input-done strobes
//   kp_state_t           : scanner FSM states
//   keymap()             : (row, column) position -> hex key code (Pmod KYPD layout)
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_DONE  = 4'hD;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        PRESSED
    } kp_state_t;

    // Layout, column 0 leftmost:
    //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
    function automatic logic [3:0] keymap(input logic [1:0] row_idx,
                                          input logic [1:0] col_idx);
        logic [3:0] code;
        code = 4'h0;
        case ({row_idx, col_idx})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'h0;
            4'hD:    code = 4'hF;
            4'hE:    code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// -----------------------------------------------------------------------------
// keypad_row_sync
// Two-flop synchroniser for the asynchronous, active-low keypad rows.
// Resets to all-high so an idle keypad is seen from the first cycle.
//   clk      in   system clock
//   rst      in   asynchronous reset, active-high
//   row_n_i  in   raw keypad rows (active-low, asynchronous)
//   rs_o     out  synchronised rows
// -----------------------------------------------------------------------------
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n_i,
    output logic [3:0] rs_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= row_n_i;
            sync_q <= meta_q;
        end
    end

    assign rs_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 matrix keypad one column at a time, debounces the synchronised
// rows and emits exactly one event per physical press (a held key never
// repeats). Digit keys raise digit_valid, E raises enter_pulse, D raises
// done_pulse, each together with key_valid for one cycle.
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   row_n        in   keypad rows, active-low, asynchronous
//   col_n        out  column drive, exactly one column low
//   key_code     out  last accepted key, held until the next one
//   key_valid    out  one-cycle pulse per accepted press
//   key_held     out  high from key_valid until the release is accepted
//   digit_valid  out  key_valid for keys other than E / D
//   enter_pulse  out  key_valid for key E
//   done_pulse   out  key_valid for key D
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       digit_valid,
    output logic       enter_pulse,
    output logic       done_pulse
);

    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int BW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [BW-1:0] DEB_DONE   = BW'(DEBOUNCE_SCANS);

    logic [3:0] rs;

    kp_state_t  state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] deb_q, deb_d;
    logic [3:0] col_q, col_d;
    logic [3:0] pat_q, pat_d;
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       held_q, held_d;
    logic       digit_q, digit_d;
    logic       enter_q, enter_d;
    logic       done_q, done_d;

    logic       sample;
    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic [3:0] col_next;
    logic [3:0] new_code;

    keypad_row_sync u_row_sync (
        .clk     (clk),
        .rst     (rst),
        .row_n_i (row_n),
        .rs_o    (rs)
    );

    // Free-running dwell: samples stay on a fixed period regardless of state,
    // so a column advanced on release gets a slightly short first dwell. The
    // synchroniser still settles well before that column's sample.
    assign sample  = (dwell_q == DWELL_LAST);
    assign dwell_d = sample ? '0 : dwell_q + DW'(1);

    // Rotate left: col0 -> col1 -> col2 -> col3 -> col0.
    assign col_next = {col_q[2:0], col_q[3]};

    always_comb begin
        col_idx = 2'd3;
        case (col_q)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            default: col_idx = 2'd3;
        endcase
    end

    // Lowest low row in the latched pattern wins when several rows are low.
    always_comb begin
        row_idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!pat_q[i]) row_idx = 2'(i);
        end
    end

    assign new_code = keymap(row_idx, col_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN;
            dwell_q <= '0;
            deb_q   <= '0;
            col_q   <= 4'b1110;
            pat_q   <= 4'hF;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            digit_q <= 1'b0;
            enter_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            deb_q   <= deb_d;
            col_q   <= col_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            digit_q <= digit_d;
            enter_q <= enter_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        col_d   = col_q;
        pat_d   = pat_q;
        code_d  = code_q;
        held_d  = held_q;
        valid_d = 1'b0;
        digit_d = 1'b0;
        enter_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (rs == 4'hF) begin
                        col_d = col_next;
                    end else begin
                        pat_d   = rs;
                        deb_d   = BW'(1);
                        state_d = CONFIRM;
                    end
                end
            end

            CONFIRM: begin
                // Acceptance is taken the cycle after the last matching
                // sample; it never coincides with a sample when dwell > 1.
                if (deb_q == DEB_DONE) begin
                    code_d  = new_code;
                    valid_d = 1'b1;
                    enter_d = (new_code == KEY_ENTER);
                    done_d  = (new_code == KEY_DONE);
                    digit_d = (new_code != KEY_ENTER) && (new_code != KEY_DONE);
                    held_d  = 1'b1;
                    deb_d   = '0;
                    state_d = PRESSED;
                end else if (sample) begin
                    if (rs == pat_q) begin
                        deb_d = deb_q + BW'(1);
                    end else begin
                        deb_d   = '0;
                        col_d   = col_next;
                        state_d = SCAN;
                    end
                end
            end

            PRESSED: begin
                // Column frozen: only the pressed key's column is watched,
                // so other keys are invisible until release is accepted.
                if (deb_q == DEB_DONE) begin
                    held_d  = 1'b0;
                    deb_d   = '0;
                    col_d   = col_next;
                    state_d = SCAN;
                end else if (sample) begin
                    deb_d = (rs == 4'hF) ? deb_q + BW'(1) : '0;
                end
            end

            default: begin
                deb_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    assign col_n       = col_q;
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_held    = held_q;
    assign digit_valid = digit_q;
    assign enter_pulse = enter_q;
    assign done_pulse  = done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised bench for keypad_scanner. A keypad model drives row_n from col_n
// and the set of pressed keys; a sample-level reference tracks what the
// scanner should report and every cycle's outputs are compared against it.
module tb_keypad_scanner;

    localparam int N   = 4;
    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid, key_held, digit_valid, enter_pulse, done_pulse;

    keypad_scanner #(.SCAN_CYCLES(N), .DEBOUNCE_SCANS(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .digit_valid (digit_valid),
        .enter_pulse (enter_pulse),
        .done_pulse  (done_pulse)
    );

    always #5 clk = ~clk;

    // Physical keypad: bit r*4+c set means the key at row r, column c is down.
    logic [15:0] pressed = '0;
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && (col_n[c] == 1'b0)) row_n[r] = 1'b0;
    end

    int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    // Reference state, advanced once per row sample.
    int         cyc;
    int         m_mode;   // 0 idle, 1 confirming, 2 holding
    int         m_cnt;
    int         m_col;
    logic [3:0] m_pat;
    int         col_chg_cyc, col_chg_val, acc_cyc, acc_code, rel_cyc;
    int         exp_col, exp_code;
    bit         exp_held;

    int n_chk  = 0;
    int n_fail = 0;
    int n_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic advance(input int c);
        m_col       = (m_col + 1) % 4;
        col_chg_cyc = c;
        col_chg_val = m_col;
    endtask

    task automatic accept(input int s);
        int lr;
        lr = 3;
        for (int r = 3; r >= 0; r--) if (!m_pat[r]) lr = r;
        acc_code = kmap[lr*4 + m_col];
        acc_cyc  = s + 2;
        m_mode   = 2;
        m_cnt    = 0;
    endtask

    task automatic model_sample(input int s);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++) if (pressed[r*4 + m_col]) rows[r] = 1'b0;
        case (m_mode)
            0: begin
                if (rows != 4'hF) begin
                    m_pat = rows; m_cnt = 1; m_mode = 1;
                    if (m_cnt == DEB) accept(s);
                end else advance(s + 1);
            end
            1: begin
                if (rows == m_pat) begin
                    m_cnt++;
                    if (m_cnt == DEB) accept(s);
                end else begin
                    m_mode = 0;
                    advance(s + 1);
                end
            end
            default: begin
                m_cnt = (rows == 4'hF) ? m_cnt + 1 : 0;
                if (m_cnt == DEB) begin
                    m_mode  = 0;
                    rel_cyc = s + 2;
                    advance(s + 2);
                end
            end
        endcase
    endtask

    task automatic tick();
        logic [3:0] ecol;
        bit ev;
        @(negedge clk);
        if (cyc == col_chg_cyc) exp_col = col_chg_val;
        if (cyc == acc_cyc) begin exp_code = acc_code; exp_held = 1'b1; end
        if (cyc == rel_cyc) exp_held = 1'b0;
        ev = (cyc == acc_cyc);
        ecol = 4'hF;
        ecol[exp_col] = 1'b0;
        chk("col_n",       col_n,       ecol);
        chk("key_valid",   key_valid,   ev);
        chk("key_code",    key_code,    exp_code);
        chk("key_held",    key_held,    exp_held);
        chk("digit_valid", digit_valid, ev && exp_code != 14 && exp_code != 13);
        chk("enter_pulse", enter_pulse, ev && exp_code == 14);
        chk("done_pulse",  done_pulse,  ev && exp_code == 13);
        if (key_valid) n_valid++;
        if (cyc % N == N - 1) model_sample(cyc);
        cyc++;
    endtask

    task automatic run(input int dwells);
        repeat (dwells * N) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_col_n",    col_n,       4'b1110);
        chk("rst_key_code", key_code,    4'h0);
        chk("rst_valid",    key_valid,   1'b0);
        chk("rst_held",     key_held,    1'b0);
        chk("rst_digit",    digit_valid, 1'b0);
        chk("rst_enter",    enter_pulse, 1'b0);
        chk("rst_done",     done_pulse,  1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0; m_mode = 0; m_cnt = 0; m_col = 0; m_pat = 4'hF;
        exp_col = 0; exp_code = 0; exp_held = 1'b0;
        col_chg_cyc = -1; acc_cyc = -1; rel_cyc = -1;
    endtask

    initial begin
        int k;
        n_valid = 0;
        do_reset();

        // Idle rotation
        run(6);

        // Key 5 held for 50 dwell periods: one event only
        n_valid = 0;
        pressed = 16'h0020;
        run(50);
        chk("k5_events", n_valid, 1);
        chk("k5_code", key_code, 4'h5);
        pressed = '0;
        run(6);

        // Key E then key D
        n_valid = 0;
        pressed = 16'h4000;
        run(12);
        chk("kE_code", key_code, 4'hE);
        pressed = '0;
        run(6);
        pressed = 16'h8000;
        run(12);
        chk("kD_code", key_code, 4'hD);
        pressed = '0;
        run(6);
        chk("kED_events", n_valid, 2);

        // Bounce: low for one sample only on the column about to be sampled
        n_valid = 0;
        pressed = 16'(1) << (4 + m_col);
        run(1);
        pressed = '0;
        run(6);
        chk("bounce_events", n_valid, 0);

        // Release glitch: 2 high, 1 low, 3 high, then re-press
        n_valid = 0;
        k = 8 + m_col;
        pressed = 16'(1) << k;
        run(DEB + 1);
        chk("glitch_held", key_held, 1'b1);
        pressed = '0;      run(2);
        pressed = 16'(1) << k; run(1);
        pressed = '0;      run(3);
        chk("held_before_rel", key_held, 1'b1);
        run(1);
        chk("held_after_rel", key_held, 1'b0);
        pressed = 16'(1) << k;
        run(10);
        chk("repress_events", n_valid, 2);
        pressed = '0;
        run(6);

        // Reset while holding a key, key re-detected afterwards
        pressed = 16'h0400;
        run(10);
        chk("pre_rst_held", key_held, 1'b1);
        do_reset();
        n_valid = 0;
        run(10);
        chk("post_rst_events", n_valid, 1);
        chk("post_rst_code", key_code, 4'h9);
        pressed = '0;
        run(6);

        // Random presses, holds, bounces and multi-key chords
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) k = (k & 12) + m_col;
            pressed = 16'(1) << k;
            if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
            run($urandom_range(1, 9));
            pressed = '0;
            run($urandom_range(0, 6));
        end
        run(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
